// File: rtl/rns_33_32_31_pkg.sv
// Shared constants and FSM state type for the {33, 32, 31} RNS reverse converter.
package rns_33_32_31_pkg;

    localparam int unsigned M1   = 33;
    localparam int unsigned M2   = 32;
    localparam int unsigned M3   = 31;
    localparam int unsigned M    = 32736;

    localparam int unsigned W1   = 6;
    localparam int unsigned W2   = 5;
    localparam int unsigned W3   = 5;
    localparam int unsigned WACC = 10;
    localparam int unsigned WOUT = 15;

    typedef enum logic [2:0] {
        IDLE,
        ADD1,
        SUB,
        ADD2,
        DONE
    } state_t;

endpackage

// File: rtl/add_mod_1023.sv
// Combinational end-around-carry adder modulo 1023; a sum of exactly 1023 folds to 0.
module add_mod_1023
    import rns_33_32_31_pkg::*;
(
    input  logic [WACC-1:0] p,
    input  logic [WACC-1:0] q,
    output logic [WACC-1:0] sum_c
);

    logic [WACC:0] s;
    logic [WACC:0] s1;

    assign s     = {1'b0, p} + {1'b0, q};
    assign s1    = s + (WACC+1)'(1);
    assign sum_c = s1[WACC] ? s1[WACC-1:0] : s[WACC-1:0];

endmodule

// File: rtl/rns_rev_seq_33_32_31.sv
// Sequential RNS {33,32,31} -> binary converter with valid/ready on both sides.
// Optional residue range check is built when RNS_REV_RANGE_CHK_EN is defined.
module rns_rev_seq_33_32_31
    import rns_33_32_31_pkg::*;
#(
    parameter int unsigned TAG_W = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W1-1:0]    x1,
    input  logic [W2-1:0]    x2,
    input  logic [W3-1:0]    x3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WOUT-1:0]  out,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    state_t            state;
    state_t            state_next;
    logic [W1-1:0]     r1;
    logic [W2-1:0]     r2;
    logic [W3-1:0]     r3;
    logic [TAG_W-1:0]  tag_q;
    logic [WACC-1:0]   acc;
    logic [WACC-1:0]   tmp;
    logic              bx;
    logic [WACC-1:0]   a1;
    logic [WACC-1:0]   a2;
    logic [WACC-1:0]   a3;
    logic [WACC-1:0]   d;
    logic [WACC-1:0]   add_p;
    logic [WACC-1:0]   add_q;
    logic [WACC-1:0]   add_sum;

    // Multiplicative-inverse coefficients expressed as rotations of the residues
    assign bx = r1[5] ^ r1[0];
    assign a1 = {bx, r1[4:1], bx, r1[4:1]};
    assign a2 = {~r2, 5'b11111};
    assign a3 = {r3[0], r3[4:1], r3[0], r3[4:1]};
    assign d  = a1 - WACC'(r1);

    add_mod_1023 u_add (
        .p     (add_p),
        .q     (add_q),
        .sum_c (add_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and shared-adder operand selection
    always_comb begin
        state_next = state;
        add_p      = a2;
        add_q      = a3;
        case (state)
            IDLE: if (in_valid) state_next = ADD1;
            ADD1: state_next = SUB;
            SUB:  state_next = ADD2;
            ADD2: begin
                add_p      = acc;
                add_q      = tmp;
                state_next = DONE;
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef RNS_REV_RANGE_CHK_EN
    logic err_q;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            tag_q     <= '0;
            acc       <= '0;
            tmp       <= '0;
            out       <= '0;
            out_tag   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef RNS_REV_RANGE_CHK_EN
            err_q     <= 1'b0;
            out_err   <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: if (in_valid) begin
                    r1    <= x1;
                    r2    <= x2;
                    r3    <= x3;
                    tag_q <= in_tag;
`ifdef RNS_REV_RANGE_CHK_EN
                    err_q <= (x1 > W1'(M1 - 1)) | (x3 == W3'(M3));
`endif
                end
                ADD1: acc <= add_sum;
                SUB:  tmp <= d;
                ADD2: begin
                    out     <= {add_sum, r2};
                    out_tag <= tag_q;
`ifdef RNS_REV_RANGE_CHK_EN
                    out_err <= err_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
